mux_scan_nx1: RTL and testbench

Parametrised N-to-1 multiplexer with a registered output and a built-in channel scanner. It is the next-generation replacement for the fixed 8:1 combinational mux. In manual mode it forwards the externally selected channel. In scan mode it steps through all channels automatically, dwelling a programmable number of cycles on each. It sits between multi-channel sources (switch banks, sensor lines, counter outputs) and a single downstream consumer such as a display driver or serial shifter.

---
 rtl/mux_scan_pkg.sv | 7 +
 rtl/mux_scan_next_ch.sv | 30 +++
 rtl/mux_scan_nx1.sv | 112 +++++++++++
 tb/tb_mux_scan_nx1.sv | 126 ++++++++++++
 4 files changed

// File: rtl/mux_scan_pkg.sv
// Shared encodings for the scanning N:1 mux: FSM states and mode input values.
package mux_scan_pkg;
  typedef enum logic {MAN = 1'b0, SCAN = 1'b1} state_t;

  localparam logic MODE_MAN  = 1'b0;
  localparam logic MODE_SCAN = 1'b1;
endpackage

// File: rtl/mux_scan_next_ch.sv
// Combinational finder: next enabled channel index after cur (circular), plus wrap flag.
module mux_scan_next_ch
  import mux_scan_pkg::*;
#(
  parameter int N_CH = 8,
  localparam int SW = $clog2(N_CH)
) (
  input  logic [SW-1:0]   cur,
  input  logic [N_CH-1:0] mask,
  output logic [SW-1:0]   nxt,
  output logic            wrapped,
  output logic            any
);

  int idx;

  always_comb begin
    nxt     = cur;
    idx     = 0;
    any     = |mask;
    // Scan offsets from farthest to nearest so the nearest enabled index wins.
    for (int k = N_CH; k >= 1; k--) begin
      idx = int'(cur) + k;
      if (idx >= N_CH) idx = idx - N_CH;
      if (mask[SW'(idx)]) nxt = SW'(idx);
    end
    wrapped = any && (nxt <= cur);
  end

endmodule

// File: rtl/mux_scan_nx1.sv
// N:1 mux with registered output and automatic channel scanner; 1-cycle latency, hold freezes state.
// Optional channel mask port and skip-scan enabled by defining MUX_SCAN_MASK_EN.
module mux_scan_nx1
  import mux_scan_pkg::*;
#(
  parameter int N_CH  = 8,
  parameter int W     = 1,
  parameter int DWELL = 4,
  localparam int SW = $clog2(N_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_CH*W-1:0] din,
  input  logic              mode,
  input  logic [SW-1:0]     sel,
  input  logic              hold,
`ifdef MUX_SCAN_MASK_EN
  input  logic [N_CH-1:0]   ch_mask,
`endif
  output logic [W-1:0]      y,
  output logic [SW-1:0]     y_ch,
  output logic              y_valid,
  output logic              wrap
);

  localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;

  state_t          state, state_n;
  logic [SW-1:0]   scan_ch, scan_ch_n, nxt_ch, out_ch;
  logic [DW-1:0]   dwell, dwell_n;
  logic            nxt_wrap, mask_any, wrap_n, ok;
  logic [W-1:0]    y_n;
  logic [N_CH-1:0] mask;
  logic [W-1:0]    ch_dat [N_CH];

`ifdef MUX_SCAN_MASK_EN
  assign mask = ch_mask;
`else
  assign mask = '1;
`endif

  for (genvar i = 0; i < N_CH; i++) begin : g_unpack
    assign ch_dat[i] = din[i*W +: W];
  end

  mux_scan_next_ch #(.N_CH(N_CH)) u_next_ch (
    .cur     (scan_ch),
    .mask    (mask),
    .nxt     (nxt_ch),
    .wrapped (nxt_wrap),
    .any     (mask_any)
  );

  always_comb begin
    state_n   = state;
    scan_ch_n = scan_ch;
    dwell_n   = dwell;
    out_ch    = sel;
    wrap_n    = 1'b0;
    unique case (state)
      MAN: begin
        if (mode == MODE_SCAN) begin
          state_n   = SCAN;
          scan_ch_n = '0;
          dwell_n   = '0;
          out_ch    = '0;
        end
      end
      SCAN: begin
        if (mode == MODE_MAN) begin
          state_n = MAN;
        end else begin
          // Outputs present the post-advance channel so each one shows exactly DWELL cycles.
          if (dwell == DW'(DWELL - 1)) begin
            dwell_n   = '0;
            scan_ch_n = nxt_ch;
            wrap_n    = nxt_wrap;
          end else begin
            dwell_n = dwell + 1'b1;
          end
          out_ch = scan_ch_n;
        end
      end
      default: state_n = MAN;
    endcase
    ok  = (int'(out_ch) < N_CH) && mask[out_ch];
    y_n = ok ? ch_dat[out_ch] : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= MAN;
      scan_ch <= '0;
      dwell   <= '0;
      y       <= '0;
      y_ch    <= '0;
      y_valid <= 1'b0;
      wrap    <= 1'b0;
    end else if (hold) begin
      wrap <= 1'b0;
    end else begin
      state   <= state_n;
      scan_ch <= scan_ch_n;
      dwell   <= dwell_n;
      y       <= y_n;
      y_ch    <= out_ch;
      y_valid <= ok;
      wrap    <= wrap_n;
    end
  end

endmodule

// File: tb/tb_mux_scan_nx1.sv
// Directed bench for mux_scan_nx1 (N_CH=8, W=1, DWELL=4) with a queue-based scoreboard.
module tb_mux_scan_nx1;

  localparam int N_CH  = 8;
  localparam int DWELL = 4;

  logic       clk = 1'b0;
  logic       rst, mode, hold;
  logic [7:0] din;
  logic [2:0] sel;
  logic [0:0] y;
  logic [2:0] y_ch;
  logic       y_valid, wrap;
`ifdef MUX_SCAN_MASK_EN
  logic [7:0] ch_mask = 8'hFF;
`endif

  always #5 clk = ~clk;

  mux_scan_nx1 #(.N_CH(N_CH), .W(1), .DWELL(DWELL)) dut (
    .clk     (clk),
    .rst     (rst),
    .din     (din),
    .mode    (mode),
    .sel     (sel),
    .hold    (hold),
`ifdef MUX_SCAN_MASK_EN
    .ch_mask (ch_mask),
`endif
    .y       (y),
    .y_ch    (y_ch),
    .y_valid (y_valid),
    .wrap    (wrap)
  );

  typedef struct packed {
    logic       y;
    logic [2:0] ych;
    logic       vld;
    logic       wr;
  } exp_t;

  exp_t sb[$];
  exp_t last_e = '0;
  int   n_assert = 0;
  int   n_fail = 0;
  bit   m_scan = 1'b0;
  int   pos = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_assert++;
    assert (got === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, expv);
    end
  endtask

  // Reference: scan position counts non-held cycles since SCAN entry.
  task automatic step(input logic r, input logic m, input logic [2:0] s,
                      input logic h, input logic [7:0] d);
    exp_t e, got;
    int ch;
    rst = r; mode = m; sel = s; hold = h; din = d;
    e = '0;
    if (r) begin
      m_scan = 1'b0;
      pos = 0;
    end else if (h) begin
      e = last_e;
      e.wr = 1'b0;
    end else if (m) begin
      if (!m_scan) begin
        m_scan = 1'b1;
        pos = 0;
      end else begin
        pos++;
      end
      ch = (pos / DWELL) % N_CH;
      e.ych = 3'(ch);
      e.y = d[ch];
      e.vld = 1'b1;
      e.wr = (pos != 0) && (pos % (N_CH * DWELL) == 0);
    end else begin
      m_scan = 1'b0;
      e.ych = s;
      e.y = d[s];
      e.vld = 1'b1;
    end
    last_e = e;
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    chk("y", 32'(y), 32'(got.y));
    chk("y_ch", 32'(y_ch), 32'(got.ych));
    chk("y_valid", 32'(y_valid), 32'(got.vld));
    chk("wrap", 32'(wrap), 32'(got.wr));
  endtask

  initial begin
    rst = 1'b1; mode = 1'b0; hold = 1'b0; din = '0; sel = '0;
    // Reset state
    step(1, 0, 0, 0, 8'h00);
    step(1, 0, 0, 0, 8'hFF);
    // Manual sweep
    for (int i = 0; i < 8; i++) step(0, 0, 3'(i), 0, 8'b1010_0110);
    // Full scan sweep, wrap, and on to channel 3 second dwell cycle
    for (int i = 0; i < 46; i++) step(0, 1, 3'(i), 0, 8'hA5);
    // Hold with mode toggling underneath
    for (int i = 0; i < 5; i++) step(0, 1'(i), 3'(i), 1, 8'($urandom));
    // Release: data tracked cycle by cycle, continue into channel 5
    for (int i = 0; i < 8; i++) step(0, 1, 0, 0, 8'($urandom));
    // SCAN -> MAN with sel=2, then back to SCAN (channel 0, no wrap)
    for (int i = 0; i < 3; i++) step(0, 0, 3'd2, 0, 8'($urandom));
    for (int i = 0; i < 10; i++) step(0, 1, 3'd6, 0, 8'($urandom));
    // Reset mid-scan, then resume in MAN
    step(1, 1, 0, 0, 8'hFF);
    step(1, 1, 0, 0, 8'hFF);
    for (int i = 0; i < 3; i++) step(0, 0, 3'd7 - 3'(i), 0, 8'($urandom));
    // Fresh scan after reset restarts at channel 0 and sweeps again
    for (int i = 0; i < 36; i++) step(0, 1, 0, 0, 8'($urandom));
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
